// File: rtl/data_channel_wrapper_if.sv
// Controller-side bundle for one BERT data channel: command/operand inputs and channel controls.
// Latency: none (wires only). Backpressure: none; commands are level-coded and edge-detected by the wrapper.
// The wrapper uses the slave modport; the BERT controller uses the master modport.
interface data_channel_wrapper_if #(
    parameter int CW = 25
);
    logic [2:0]    ctrl_sig;
    logic [2:0]    val;
    logic [2:0]    val1;
    logic [CW-1:0] earlier_cl_val;
    logic [CW-1:0] wanted_cl_val;
    logic          channel_reset;
    logic [2:0]    datawidth;
    logic          ref_clock;

    modport master (
        output ctrl_sig, val, val1, earlier_cl_val, wanted_cl_val,
        input  channel_reset, datawidth, ref_clock
    );

    modport slave (
        input  ctrl_sig, val, val1, earlier_cl_val, wanted_cl_val,
        output channel_reset, datawidth, ref_clock
    );
endinterface

// File: rtl/data_channel_wrapper.sv
// Channel control wrapper: decodes controller commands into a reset pulse, divided ref clock and width code.
// Latency: reset/width 1 edge after trigger; ref-clock retune applies at trigger+26 (25-step serial divide).
// Backpressure: none; a retune issued mid-divide restarts it. DCW_AUTO_RESET_EN adds reset pulses on width/retune.
module data_channel_wrapper #(
    parameter int CW        = 25,
    parameter int DIV_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    data_channel_wrapper_if.slave bus
);
    localparam int SW = $clog2(CW + 1);

    logic [2:0]    prev_q,      prev_d;
    logic          chan_rst_q,  chan_rst_d;
    logic [2:0]    rst_cnt_q,   rst_cnt_d;
    logic [2:0]    datawidth_q, datawidth_d;
    logic          ref_q,       ref_d;
    logic [CW-1:0] ref_cnt_q,   ref_cnt_d;
    logic [CW-1:0] half_q,      half_d;
    logic          busy_q,      busy_d;
    logic [SW-1:0] step_q,      step_d;
    logic [CW-1:0] rem_q,       rem_d;
    logic [CW-1:0] quo_q,       quo_d;
    logic [CW-1:0] dvs_q,       dvs_d;

    logic          trig;
    logic          cmd1;
    logic          cmd2;
    logic          cmd3;
    logic          div_done;
    logic          pulse_start;
    logic [CW:0]   rem_sh;
    logic [CW-1:0] new_half;

    always_comb begin
        prev_d      = bus.ctrl_sig;
        chan_rst_d  = chan_rst_q;
        rst_cnt_d   = rst_cnt_q;
        datawidth_d = datawidth_q;
        ref_d       = ref_q;
        ref_cnt_d   = ref_cnt_q;
        half_d      = half_q;
        busy_d      = busy_q;
        step_d      = step_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        new_half    = '0;

        // Commands fire only on a change of ctrl_sig, so holding a code is harmless.
        trig     = (bus.ctrl_sig != prev_q);
        cmd1     = trig && (bus.ctrl_sig == 3'd1);
        cmd2     = trig && (bus.ctrl_sig == 3'd2);
        cmd3     = trig && (bus.ctrl_sig == 3'd3);
        div_done = busy_q && (step_q == SW'(CW));
        rem_sh   = {rem_q, quo_q[CW-1]};

        if (ref_cnt_q == half_q - CW'(1)) begin
            ref_d     = ~ref_q;
            ref_cnt_d = '0;
        end else begin
            ref_cnt_d = ref_cnt_q + CW'(1);
        end

        if (dvs_q == '0) begin
            new_half = CW'(1) << (CW - 1);
        end else if (quo_q[CW-1:1] == '0) begin
            new_half = CW'(1);
        end else begin
            new_half = {1'b0, quo_q[CW-1:1]};
        end

        if (cmd2) begin
            busy_d = 1'b1;
            step_d = '0;
            rem_d  = '0;
            quo_d  = bus.earlier_cl_val;
            dvs_d  = bus.wanted_cl_val;
        end else if (div_done) begin
            busy_d    = 1'b0;
            half_d    = new_half;
            ref_cnt_d = '0;
            ref_d     = 1'b0;
        end else if (busy_q) begin
            // One restoring step: shift the next dividend bit into the remainder.
            step_d = step_q + SW'(1);
            if (rem_sh >= {1'b0, dvs_q}) begin
                rem_d = CW'(rem_sh - {1'b0, dvs_q});
                quo_d = {quo_q[CW-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[CW-1:0];
                quo_d = {quo_q[CW-2:0], 1'b0};
            end
        end

`ifdef DCW_AUTO_RESET_EN
        pulse_start = cmd1 || cmd3 || div_done;
`else
        pulse_start = cmd1;
`endif

        if (pulse_start) begin
            chan_rst_d = 1'b1;
            rst_cnt_d  = bus.val;
        end else if (chan_rst_q) begin
            if (rst_cnt_q == 3'd0) begin
                chan_rst_d = 1'b0;
            end else begin
                rst_cnt_d = rst_cnt_q - 3'd1;
            end
        end

        if (cmd3) begin
            datawidth_d = bus.val1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '0;
            chan_rst_q  <= 1'b0;
            rst_cnt_q   <= '0;
            datawidth_q <= '0;
            ref_q       <= 1'b0;
            ref_cnt_q   <= '0;
            half_q      <= CW'(DIV_RESET);
            busy_q      <= 1'b0;
            step_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
        end else begin
            prev_q      <= prev_d;
            chan_rst_q  <= chan_rst_d;
            rst_cnt_q   <= rst_cnt_d;
            datawidth_q <= datawidth_d;
            ref_q       <= ref_d;
            ref_cnt_q   <= ref_cnt_d;
            half_q      <= half_d;
            busy_q      <= busy_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
        end
    end

    assign bus.channel_reset = chan_rst_q;
    assign bus.datawidth     = datawidth_q;
    assign bus.ref_clock     = ref_q;
endmodule

// File: tb/tb_data_channel_wrapper.sv
// Directed bench for data_channel_wrapper; expectations follow DCW_AUTO_RESET_EN when it is defined.
module tb_data_channel_wrapper;
    localparam int CW = 25;
`ifdef DCW_AUTO_RESET_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic exp_ref = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    data_channel_wrapper_if #(.CW(CW)) bus ();

    data_channel_wrapper #(.CW(CW), .DIV_RESET(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Advance while the ref clock runs at half-period 1, checking every toggle.
    task automatic tick_h1(input int n, input string tag);
        repeat (n) begin
            tick(1);
            exp_ref = ~exp_ref;
            check(tag, 32'(bus.ref_clock), 32'(exp_ref));
        end
    endtask

    initial begin
        bus.ctrl_sig       = 3'd0;
        bus.val            = 3'd0;
        bus.val1           = 3'd0;
        bus.earlier_cl_val = '0;
        bus.wanted_cl_val  = '0;

        #2;
        check("rst_chan_reset", 32'(bus.channel_reset), 32'd0);
        check("rst_datawidth",  32'(bus.datawidth),     32'd0);
        check("rst_ref_clock",  32'(bus.ref_clock),     32'd0);
        tick(2);
        check("rst_hold_ref",   32'(bus.ref_clock),     32'd0);
        reset_n = 1'b1;

        // Idle: default half-period 1 gives a 2-clock ref period.
        tick_h1(4, "idle_ref");

        // Command 1, val=7: eight clocks of channel_reset.
        bus.ctrl_sig = 3'd1;
        bus.val      = 3'd7;
        for (int i = 0; i < 8; i++) begin
            tick_h1(1, "c1_ref");
            check("c1_pulse_high", 32'(bus.channel_reset), 32'd1);
            check("c1_datawidth",  32'(bus.datawidth),     32'd0);
        end
        tick_h1(1, "c1_ref");
        check("c1_pulse_end", 32'(bus.channel_reset), 32'd0);
        bus.ctrl_sig = 3'd0;
        tick_h1(1, "c1_ref");

        // Command 2: 20M/10M -> N=2, H=1.
        bus.earlier_cl_val = 25'd20000000;
        bus.wanted_cl_val  = 25'd10000000;
        bus.ctrl_sig       = 3'd2;
        tick_h1(1, "c2a_ref_trig");
        bus.ctrl_sig = 3'd0;
        tick_h1(25, "c2a_ref_busy");
        tick(1);
        check("c2a_ref_apply",  32'(bus.ref_clock),     32'd0);
        check("c2a_auto_pulse", 32'(bus.channel_reset), 32'(AUTO));
        exp_ref = 1'b0;
        tick_h1(12, "c2a_ref_after");

        // Command 2: 20M/2.5M -> N=8, H=4, period 8.
        bus.wanted_cl_val = 25'd2500000;
        bus.ctrl_sig      = 3'd2;
        tick_h1(1, "c2b_ref_trig");
        bus.ctrl_sig = 3'd0;
        tick_h1(25, "c2b_ref_busy");
        tick(1);
        check("c2b_ref_apply", 32'(bus.ref_clock), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            check("c2b_ref_h4", 32'(bus.ref_clock), 32'((k / 4) % 2));
        end

        // Command 3: code 13 truncates to 5; holding the command does not reload.
        bus.ctrl_sig = 3'd3;
        bus.val1     = 3'(13);
        bus.val      = 3'd2;
        tick(1);
        check("c3_datawidth",  32'(bus.datawidth),     32'd5);
        check("c3_auto_t0",    32'(bus.channel_reset), 32'(AUTO));
        bus.val1 = 3'd2;
        tick(1);
        check("c3_hold_width", 32'(bus.datawidth),     32'd5);
        check("c3_auto_t1",    32'(bus.channel_reset), 32'(AUTO));
        tick(1);
        check("c3_auto_t2",    32'(bus.channel_reset), 32'(AUTO));
        tick(1);
        check("c3_auto_end",   32'(bus.channel_reset), 32'd0);
        check("c3_hold_width2", 32'(bus.datawidth),    32'd5);

        // Divide-by-zero request restarted at T+10 by a 20M/10M request.
        bus.ctrl_sig = 3'd0;
        tick(1);
        bus.wanted_cl_val = '0;
        bus.ctrl_sig      = 3'd2;
        tick(1);
        bus.ctrl_sig = 3'd0;
        tick(8);
        bus.wanted_cl_val = 25'd10000000;
        bus.ctrl_sig      = 3'd2;
        tick(1);
        bus.ctrl_sig = 3'd0;
        tick(25);
        tick(1);
        check("c2r_ref_apply", 32'(bus.ref_clock), 32'd0);
        exp_ref = 1'b0;
        tick_h1(4, "c2r_second_only");

        // Divide-by-zero alone: H=2^24, ref holds 0 long after apply.
        bus.wanted_cl_val = '0;
        bus.ctrl_sig      = 3'd2;
        tick(1);
        bus.ctrl_sig = 3'd0;
        tick(25);
        tick(1);
        check("c2z_ref_apply", 32'(bus.ref_clock), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("c2z_ref_hold", 32'(bus.ref_clock), 32'd0);
        end

        // Reset three clocks into an 8-clock pulse.
        bus.ctrl_sig = 3'd1;
        bus.val      = 3'd7;
        tick(1);
        bus.ctrl_sig = 3'd0;
        tick(3);
        check("mid_pulse_high", 32'(bus.channel_reset), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_chan",  32'(bus.channel_reset), 32'd0);
        check("mid_rst_width", 32'(bus.datawidth),     32'd0);
        check("mid_rst_ref",   32'(bus.ref_clock),     32'd0);
        tick(2);
        reset_n = 1'b1;
        exp_ref = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_h1(1, "post_rst_ref");
            check("post_rst_no_pulse", 32'(bus.channel_reset), 32'd0);
        end
        check("post_rst_width", 32'(bus.datawidth), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
